// File: rtl/fsm_alu_pkg.sv
// Shared constants for the FSM + ALU demonstrator: state codes, op codes and
// the fixed operand schedule.
package fsm_alu_pkg;

    localparam int unsigned W = 7;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_ADD  = 2'd1;
    localparam state_t S_SUB  = 2'd2;
    localparam state_t S_NEXT = 2'd3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [W-1:0] A_SEED = 7'd25;
    localparam logic [W-1:0] B_SEED = 7'd10;
    localparam logic [W-1:0] A_STEP = 7'd37;
    localparam logic [W-1:0] B_STEP = 7'd53;

endpackage

// File: rtl/alu7.sv
// Combinational 7-bit add/subtract ALU with carry/borrow and a flag for a
// strictly positive true (unwrapped) result.
module alu7
    import fsm_alu_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] res_o,
    output logic         cf_o,
    output logic         gz_o
);

    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum  = {1'b0, a_i} + {1'b0, b_i};
        diff = {1'b0, a_i} - {1'b0, b_i};
        if (sub_i) begin
            // The extended bit of the difference is the borrow, i.e. a < b.
            res_o = diff[W-1:0];
            cf_o  = diff[W];
            gz_o  = (a_i > b_i);
        end else begin
            res_o = sum[W-1:0];
            cf_o  = sum[W];
            gz_o  = ((a_i | b_i) != '0);
        end
    end

endmodule

// File: rtl/fsm_alu_controller.sv
// Free-running controller that walks a fixed operand schedule through alu7
// and registers operands, operation and flagged result.
module fsm_alu_controller
    import fsm_alu_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic         op_o,
    output logic [W-1:0] res_o,
    output logic         cf_o,
    output logic         gz_o
);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           op_q, op_d;
    logic [W-1:0]   res_q, res_d;
    logic           cf_q, cf_d;
    logic           gz_q, gz_d;

    logic [W-1:0]   alu_res;
    logic           alu_cf;
    logic           alu_gz;

    // Operation select comes from the state, never from the registered op.
    alu7 u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .sub_i (state_q == S_SUB),
        .res_o (alu_res),
        .cf_o  (alu_cf),
        .gz_o  (alu_gz)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        cf_d    = cf_q;
        gz_d    = gz_q;
        unique case (state_q)
            S_IDLE: begin
                a_d     = A_SEED;
                b_d     = B_SEED;
                state_d = S_ADD;
            end
            S_ADD: begin
                res_d   = alu_res;
                cf_d    = alu_cf;
                gz_d    = alu_gz;
                op_d    = OP_ADD;
                state_d = S_SUB;
            end
            S_SUB: begin
                res_d   = alu_res;
                cf_d    = alu_cf;
                gz_d    = alu_gz;
                op_d    = OP_SUB;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                a_d     = a_q + A_STEP;
                b_d     = b_q + B_STEP;
                state_d = S_ADD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            res_q   <= '0;
            cf_q    <= 1'b0;
            gz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cf_q    <= cf_d;
            gz_q    <= gz_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign op_o  = op_q;
    assign res_o = res_q;
    assign cf_o  = cf_q;
    assign gz_o  = gz_q;

endmodule

// File: tb/tb_fsm_alu_controller.sv
// Scoreboard bench: a driver steps a phase-based reference model and queues the
// expected outputs per edge; a monitor pops and compares every cycle.
module tb_fsm_alu_controller;

    logic       clk;
    logic       rst;
    logic [6:0] a, b, res;
    logic       op, cf, gz;

    logic [6:0] ta, tb_b, tres;
    logic       tsub, tcf, tgz;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int a; int b; int op; int res; int cf; int gz; int tag;
    } exp_t;

    exp_t sb_q[$];

    fsm_alu_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .a_o   (a),
        .b_o   (b),
        .op_o  (op),
        .res_o (res),
        .cf_o  (cf),
        .gz_o  (gz)
    );

    alu7 u_alu_chk (
        .a_i   (ta),
        .b_i   (tb_b),
        .sub_i (tsub),
        .res_o (tres),
        .cf_o  (tcf),
        .gz_o  (tgz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Directed schedule after the first reset: {a, b, op, res, cf, gz}.
    int dir_tab[11][6] = '{
        '{25, 10, 0,   0, 0, 0},
        '{25, 10, 0,  35, 0, 1},
        '{25, 10, 1,  15, 0, 1},
        '{62, 63, 1,  15, 0, 1},
        '{62, 63, 0, 125, 0, 1},
        '{62, 63, 1, 127, 1, 0},
        '{99, 116, 1, 127, 1, 0},
        '{99, 116, 0,  87, 1, 1},
        '{99, 116, 1, 111, 1, 0},
        '{ 8, 41, 1, 111, 1, 0},
        '{ 8, 41, 0,  49, 0, 1}
    };

    // Reference model: phase 0 loads seeds, 1 adds, 2 subtracts, 3 advances.
    int m_phase, m_a, m_b, m_op, m_res, m_cf, m_gz;

    task automatic model_step(input logic r, input int tag);
        exp_t e;
        int   t;
        if (r) begin
            m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_cf = 0; m_gz = 0;
        end else begin
            case (m_phase)
                0: begin m_a = 25; m_b = 10; m_phase = 1; end
                1: begin
                    t = m_a + m_b;
                    m_res = t % 128; m_cf = (t > 127); m_gz = (t > 0); m_op = 0;
                    m_phase = 2;
                end
                2: begin
                    t = m_a - m_b;
                    m_res = (t + 128) % 128; m_cf = (t < 0); m_gz = (t > 0); m_op = 1;
                    m_phase = 3;
                end
                default: begin
                    m_a = (m_a + 37) % 128; m_b = (m_b + 53) % 128; m_phase = 1;
                end
            endcase
        end
        e = '{m_a, m_b, m_op, m_res, m_cf, m_gz, tag};
        sb_q.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("a",   int'(a),   e.a);
                check("b",   int'(b),   e.b);
                check("op",  int'(op),  e.op);
                check("res", int'(res), e.res);
                check("cf",  int'(cf),  e.cf);
                check("gz",  int'(gz),  e.gz);
                if (e.tag >= 0) begin
                    check("dir_a",   int'(a),   dir_tab[e.tag][0]);
                    check("dir_b",   int'(b),   dir_tab[e.tag][1]);
                    check("dir_op",  int'(op),  dir_tab[e.tag][2]);
                    check("dir_res", int'(res), dir_tab[e.tag][3]);
                    check("dir_cf",  int'(cf),  dir_tab[e.tag][4]);
                    check("dir_gz",  int'(gz),  dir_tab[e.tag][5]);
                end
            end
        end
    end

    // Standalone ALU corners plus random vectors against plain arithmetic.
    initial begin
        int ra, rb, t;
        int corner[4][6] = '{
            '{127, 1, 0,   0, 1, 1},
            '{  0, 0, 0,   0, 0, 0},
            '{  5, 5, 1,   0, 0, 0},
            '{  0, 1, 1, 127, 1, 0}
        };
        for (int i = 0; i < 4; i++) begin
            ta = 7'(corner[i][0]); tb_b = 7'(corner[i][1]); tsub = corner[i][2][0];
            #1;
            check("alu_corner_res", int'(tres), corner[i][3]);
            check("alu_corner_cf",  int'(tcf),  corner[i][4]);
            check("alu_corner_gz",  int'(tgz),  corner[i][5]);
        end
        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(0, 127));
            rb = int'($urandom_range(0, 127));
            tsub = 1'($urandom_range(0, 1));
            ta = 7'(ra); tb_b = 7'(rb);
            #1;
            t = tsub ? ra - rb : ra + rb;
            check("alu_rand_res", int'(tres), (t + 128) % 128);
            check("alu_rand_cf",  int'(tcf),  tsub ? int'(t < 0) : int'(t > 127));
            check("alu_rand_gz",  int'(tgz),  int'(t > 0));
        end
    end

    // Driver: choose rst before each edge and queue the model's view of that edge.
    initial begin
        bit sub_reset_done = 0;
        rst = 1'b1;
        model_step(1'b1, -1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc < 1) begin
                rst = 1'b1;
            end else if (cyc <= 14) begin
                rst = 1'b0;
            end else if (!sub_reset_done && m_phase == 2) begin
                rst = 1'b1;
                sub_reset_done = 1;
            end else if (rst) begin
                rst = ($urandom_range(0, 1) == 0);
            end else begin
                rst = ($urandom_range(0, 29) == 0);
            end
            model_step(rst, (cyc >= 1 && cyc <= 11) ? cyc - 1 : -1);
        end
        @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        check("sub_reset_exercised", int'(sub_reset_done), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
